// File: rtl/accelerator_fnn_vector_feeder_pkg.sv
// Shared accelerator FNN controller definitions: data/control widths, constants
// and the vector feeder state encoding.
package accelerator_fnn_vector_feeder_pkg;

  localparam int unsigned DATA_SIZE    = 64;
  localparam int unsigned CONTROL_SIZE = 64;
  localparam int unsigned ADDRESS_SIZE = 4;

  localparam logic [CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
  localparam logic [CONTROL_SIZE-1:0] ONE_CONTROL  = CONTROL_SIZE'(1);
  localparam logic [DATA_SIZE-1:0]    ZERO_DATA    = '0;

  typedef enum logic [1:0] {
    FEEDER_IDLE   = 2'd0,
    FEEDER_STREAM = 2'd1,
    FEEDER_DONE   = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/accelerator_fnn_vector_buffer.sv
// Element buffer for the vector feeder: synchronous write, registered read that
// holds its value between reads, read-before-write on address collision.
module accelerator_fnn_vector_buffer #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned ADDRESS_SIZE = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [ADDRESS_SIZE-1:0] wr_addr_i,
  input  logic [DATA_SIZE-1:0]    wr_data_i,
  input  logic                    rd_en_i,
  input  logic [ADDRESS_SIZE-1:0] rd_addr_i,
  output logic [DATA_SIZE-1:0]    rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDRESS_SIZE;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] rd_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/accelerator_fnn_vector_feeder.sv
// Streams buffered vector elements to the FNN controller one per request,
// with a one-cycle READY pulse once the requested length has been delivered.
module accelerator_fnn_vector_feeder #(
  parameter int unsigned DATA_SIZE    = accelerator_fnn_vector_feeder_pkg::DATA_SIZE,
  parameter int unsigned CONTROL_SIZE = accelerator_fnn_vector_feeder_pkg::CONTROL_SIZE,
  parameter int unsigned ADDRESS_SIZE = accelerator_fnn_vector_feeder_pkg::ADDRESS_SIZE
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic                    WRITE_ENABLE,
  input  logic [ADDRESS_SIZE-1:0] WRITE_ADDRESS,
  input  logic [DATA_SIZE-1:0]    WRITE_DATA,
  input  logic                    DATA_REQUEST,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  import accelerator_fnn_vector_feeder_pkg::*;

  localparam int unsigned              DEPTH    = 1 << ADDRESS_SIZE;
  localparam logic [CONTROL_SIZE-1:0]  CTRL_0   = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0]  CTRL_1   = CONTROL_SIZE'(ONE_CONTROL);
  localparam logic [CONTROL_SIZE-1:0]  CTRL_MAX = CONTROL_SIZE'(DEPTH);

  feeder_state_e           state_q, state_d;
  logic [CONTROL_SIZE-1:0] index_q, index_d;
  logic [CONTROL_SIZE-1:0] length_q, length_d;
  logic                    ready_q, ready_d;
  logic                    out_en_q;
  logic                    serve_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= FEEDER_IDLE;
      index_q  <= CTRL_0;
      length_q <= CTRL_0;
      ready_q  <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      length_q <= length_d;
      ready_q  <= ready_d;
      out_en_q <= serve_c;
    end
  end

  // A zero-length stream raises READY straight from IDLE; DONE then stays silent.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    length_d = length_q;
    ready_d  = 1'b0;
    serve_c  = 1'b0;
    case (state_q)
      FEEDER_IDLE: begin
        if (START) begin
          length_d = (SIZE_IN > CTRL_MAX) ? CTRL_MAX : SIZE_IN;
          index_d  = CTRL_0;
          if (SIZE_IN == CTRL_0) begin
            state_d = FEEDER_DONE;
            ready_d = 1'b1;
          end else begin
            state_d = FEEDER_STREAM;
          end
        end
      end
      FEEDER_STREAM: begin
        if (DATA_REQUEST) begin
          serve_c = 1'b1;
          if (index_q == length_q - CTRL_1) begin
            state_d = FEEDER_DONE;
          end else begin
            index_d = index_q + CTRL_1;
          end
        end
      end
      FEEDER_DONE: begin
        ready_d = (length_q != CTRL_0);
        state_d = FEEDER_IDLE;
      end
      default: begin
        state_d = FEEDER_IDLE;
      end
    endcase
  end

  accelerator_fnn_vector_buffer #(
    .DATA_SIZE    (DATA_SIZE),
    .ADDRESS_SIZE (ADDRESS_SIZE)
  ) u_buffer (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .wr_en_i   (WRITE_ENABLE),
    .wr_addr_i (WRITE_ADDRESS),
    .wr_data_i (WRITE_DATA),
    .rd_en_i   (serve_c),
    .rd_addr_i (index_q[ADDRESS_SIZE-1:0]),
    .rd_data_o (DATA_OUT)
  );

  assign READY           = ready_q;
  assign DATA_OUT_ENABLE = out_en_q;

endmodule

// File: doc/accelerator_fnn_vector_feeder.md
ACCELERATOR_FNN_VECTOR_FEEDER -- requirements
Module: accelerator_fnn_vector_feeder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, width of one vector element.
REQ-002 SHALL have parameter CONTROL_SIZE, default 64, width of length/index values.
REQ-003 SHALL have parameter ADDRESS_SIZE, default 4, buffer depth 2**ADDRESS_SIZE (16 elements).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 RST  in  1  asynchronous active-low reset.
REQ-007 START  in  1  begin streaming; sampled only in IDLE.
REQ-008 READY  out  1  one-cycle pulse: stream complete.
REQ-009 SIZE_IN  in  CONTROL_SIZE  element count for this stream.
REQ-010 WRITE_ENABLE  in  1  load strobe into buffer.
REQ-011 WRITE_ADDRESS  in  ADDRESS_SIZE  buffer load index.
REQ-012 WRITE_DATA  in  DATA_SIZE  buffer load value.
REQ-013 DATA_REQUEST  in  1  consumer (FNN controller) asks for next element.
REQ-014 DATA_OUT_ENABLE  out  1  one-cycle strobe: DATA_OUT valid.
REQ-015 DATA_OUT  out  DATA_SIZE  element being delivered.

Function
REQ-016 SHALL implement states IDLE, STREAM, DONE.
REQ-017 In IDLE with START=1: latch length = min(SIZE_IN, 2**ADDRESS_SIZE), index = 0; go STREAM, or DONE if SIZE_IN = 0.
REQ-018 In STREAM, DATA_REQUEST=1 in cycle n SHALL give DATA_OUT = buffer[index], DATA_OUT_ENABLE=1 in cycle n+1 (one-cycle latency), index incremented.
REQ-019 Back-to-back DATA_REQUEST SHALL give back-to-back DATA_OUT_ENABLE, one element per cycle, no bubbles.
REQ-020 Request serving index = length-1 SHALL move to DONE; no further element emitted for that stream.
REQ-021 DONE SHALL assert READY for exactly one cycle (cycle after final DATA_OUT_ENABLE, or cycle after START when length 0), then return to IDLE.
REQ-022 DATA_OUT_ENABLE SHALL be 0 in every cycle not following a served request; DATA_OUT SHALL hold its last value between strobes.
REQ-023 DATA_REQUEST in IDLE or DONE SHALL be ignored (no strobe, no index change).
REQ-024 START outside IDLE SHALL be ignored; SIZE_IN only sampled on accepted START.
REQ-025 WRITE_ENABLE SHALL be accepted in any state; write completes at clock edge.
REQ-026 Write and read of same address in same cycle SHALL return old contents (read-before-write).
REQ-027 Index SHALL never exceed length-1; no wrap within a stream.

Reset
REQ-028 RST=0 SHALL immediately force IDLE, READY=0, DATA_OUT_ENABLE=0, DATA_OUT=ZERO_DATA, index=ZERO_CONTROL, length=ZERO_CONTROL, all buffer entries ZERO_DATA.
REQ-029 Reset mid-stream SHALL abort the stream with no READY pulse; first START after release starts a fresh stream.

Structure
REQ-030 DATA_SIZE, CONTROL_SIZE, ZERO_CONTROL, ONE_CONTROL, ZERO_DATA SHALL come from the shared accelerator FNN controller package; ADDRESS_SIZE default and the feeder state enum SHALL be added there.
REQ-031 Buffer SHALL be one sub-module accelerator_fnn_vector_buffer (sync write, registered read, async reset); FSM and counters in the top.

Verification
REQ-032 Load buffer[0..3]=1,2,3,4; START, SIZE_IN=4; DATA_REQUEST high 4 cycles -> DATA_OUT_ENABLE 4 consecutive cycles with 1,2,3,4, READY next cycle only.
REQ-033 Same load, requests every 3rd cycle -> strobes one cycle after each request, DATA_OUT held between, READY after 4th element.
REQ-034 START with SIZE_IN=0 -> READY one cycle later, no DATA_OUT_ENABLE; SIZE_IN=40 -> exactly 16 elements then READY.
REQ-035 Mid-stream (after 2 of 4): RST low 1 cycle -> outputs zero immediately, no READY; new START streams zeros from reset buffer.
REQ-036 During STREAM, write buffer[1]=99 in the same cycle as the request for index 1 -> old value 2 delivered; second stream delivers 99.
REQ-037 DATA_REQUEST in IDLE and START during STREAM -> no strobe, stream length and index unchanged.
